id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 64 ++++++
 rtl/id_ex_stage_imm_gen.sv | 32 +++
 rtl/id_ex_stage.sv | 116 +++++++++++
 tb/tb_id_ex_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared decode types for the ID/EX pipeline stage:
// ALU op codes, RV32I major opcodes and instruction formats.
package id_ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef enum logic [2:0] {
    T_R, T_I, T_S, T_B, T_U, T_J, T_BAD
  } itype_t;

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  function automatic itype_t itype_of(logic [6:0] op);
    itype_t t;
    case (op)
      OP_REG:                     t = T_R;
      OP_IMM, OP_LOAD, OP_JALR:   t = T_I;
      OP_STORE:                   t = T_S;
      OP_BRANCH:                  t = T_B;
      OP_LUI, OP_AUIPC:           t = T_U;
      OP_JAL:                     t = T_J;
      default:                    t = T_BAD;
    endcase
    return t;
  endfunction

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic alu_op_t alu_of(logic [2:0] f3, logic alt);
    alu_op_t r;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// Immediate generator: sign-extends the RV32I immediate of
// each instruction format to the datapath width.
module imm_gen
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           instr,
  output logic [DATA_WIDTH-1:0] imm
);

  logic [31:0] raw;

  always_comb begin
    raw = '0;
    case (itype_of(instr[6:0]))
      T_I: raw = {{20{instr[31]}}, instr[31:20]};
      T_S: raw = {{20{instr[31]}}, instr[31:25],
                  instr[11:7]};
      T_B: raw = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
      T_U: raw = {instr[31:12], 12'b0};
      T_J: raw = {{11{instr[31]}}, instr[31],
                  instr[19:12], instr[20],
                  instr[30:21], 1'b0};
      default: raw = '0;
    endcase
  end

  assign imm = DATA_WIDTH'($signed(raw));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes an RV32I word and holds
// the ALU operands in a one-entry valid/ready buffer.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instr,
  input  logic [DATA_WIDTH-1:0]    pc,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [DATA_WIDTH-1:0]    Immediate,
  output logic [DATA_WIDTH-1:0]    pc_q,
  output logic [OPCODE_LENGTH-1:0] ALUCtl,
  output logic [4:0]               rd_addr,
  output logic                     reg_write,
  output logic                     alu_src,
  output logic                     illegal
);

  state_t state, state_nx;
  logic   capture;

  logic [6:0] opcode;
  logic [4:0] rd;
  itype_t     ityp;
  alu_op_t    alu;
  logic       rw_d, as_d, ill_d;
  logic [DATA_WIDTH-1:0] srca_d, imm;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];

  imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm (
    .instr (instr),
    .imm   (imm)
  );

  always_comb begin
    ityp  = itype_of(opcode);
    ill_d = (ityp == T_BAD);
    as_d  = ityp inside {T_I, T_S, T_U, T_J};
    rw_d  = (ityp inside {T_R, T_I, T_U, T_J})
            && (rd != 5'd0);
    alu   = ALU_ADD;
    if (opcode == OP_REG)
      alu = alu_of(instr[14:12], instr[30]);
    else if (opcode == OP_IMM)
      alu = alu_of(instr[14:12],
                   instr[30] && instr[14:12] == 3'b101);
    else if (opcode == OP_BRANCH)
      case (instr[14:13])
        2'b10:   alu = ALU_SLT;
        2'b11:   alu = ALU_SLTU;
        default: alu = ALU_SUB;
      endcase
    srca_d = rs1_data;
    unique case (1'b1)
      opcode == OP_LUI:   srca_d = '0;
      opcode == OP_AUIPC,
      opcode == OP_JAL:   srca_d = pc;
      default:            srca_d = rs1_data;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= EMPTY;
    else       state <= state_nx;

  always_comb begin
    in_ready = (state == EMPTY) || out_ready;
    capture  = in_valid && in_ready && !flush;
    state_nx = state;
    if (flush)          state_nx = EMPTY;
    else if (capture)   state_nx = FULL;
    else if (out_ready) state_nx = EMPTY;
  end

  assign out_valid = (state == FULL);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      SrcA      <= '0;
      SrcB      <= '0;
      Immediate <= '0;
      pc_q      <= '0;
      ALUCtl    <= '0;
      rd_addr   <= '0;
      reg_write <= 1'b0;
      alu_src   <= 1'b0;
      illegal   <= 1'b0;
    end else if (capture) begin
      SrcA      <= srca_d;
      SrcB      <= rs2_data;
      Immediate <= imm;
      pc_q      <= pc;
      ALUCtl    <= OPCODE_LENGTH'(alu);
      rd_addr   <= rd;
      reg_write <= rw_d;
      alu_src   <= as_d;
      illegal   <= ill_d;
    end else if (state_nx == EMPTY) begin
      reg_write <= 1'b0;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: decode vector table through a
// scoreboard, plus stall, flush and reset sequences.
module tb_id_ex_stage;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic [31:0] srca, imm;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rw, as, ill, m_alu, m_ops;
  } vec_t;

  logic        clk = 0;
  logic        reset, in_valid, in_ready, flush;
  logic        out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [31:0] SrcA, SrcB, Immediate, pc_q;
  logic [3:0]  ALUCtl;
  logic [4:0]  rd_addr;
  logic        reg_write, alu_src, illegal;

  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];
  vec_t q[$];
  vec_t cur;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Immediate (Immediate),
    .pc_q      (pc_q),
    .ALUCtl    (ALUCtl),
    .rd_addr   (rd_addr),
    .reg_write (reg_write),
    .alu_src   (alu_src),
    .illegal   (illegal)
  );

  task automatic chk(string n, logic [31:0] a,
                     logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, x);
    end
  endtask

  task automatic add(logic [31:0] i, p, r1, r2, sa, im,
                     logic [3:0] al, logic [4:0] rd,
                     logic rw, as, ill, ma, mo);
    vec_t v;
    v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2;
    v.srca = sa; v.imm = im; v.alu = al; v.rd = rd;
    v.rw = rw; v.as = as; v.ill = ill;
    v.m_alu = ma; v.m_ops = mo;
    tbl.push_back(v);
  endtask

  task automatic cmp(vec_t e);
    string s;
    s = $sformatf("%h", e.instr);
    if (e.m_ops) begin
      chk({"srca@", s}, SrcA, e.srca);
      chk({"srcb@", s}, SrcB, e.rs2);
      chk({"imm@", s}, Immediate, e.imm);
      chk({"alu_src@", s}, 32'(alu_src), 32'(e.as));
    end
    if (e.m_alu) chk({"aluctl@", s}, 32'(ALUCtl), 32'(e.alu));
    chk({"pc_q@", s}, pc_q, e.pc);
    chk({"rd@", s}, 32'(rd_addr), 32'(e.rd));
    chk({"reg_write@", s}, 32'(reg_write), 32'(e.rw));
    chk({"illegal@", s}, 32'(illegal), 32'(e.ill));
    if (e.instr == 32'hFFB20193)
      chk("sum_neg", SrcA + Immediate, 32'hFFFFFFF6);
  endtask

  always @(negedge clk) begin
    if (reset) q.delete();
    else begin
      if (out_valid && (out_ready || flush)) begin
        if (q.size() == 0) chk("sb_empty", 32'(out_valid), 0);
        else begin
          vec_t e;
          e = q.pop_front();
          if (out_ready) cmp(e);
        end
      end
      if (in_valid && in_ready && !flush) q.push_back(cur);
    end
  end

  task automatic drive(vec_t v, logic iv, logic ordy,
                       logic fl);
    @(posedge clk);
    #1;
    cur = v;
    instr = v.instr; pc = v.pc;
    rs1_data = v.rs1; rs2_data = v.rs2;
    in_valid = iv; out_ready = ordy; flush = fl;
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && q.size() != 0; k++)
      @(negedge clk);
    chk("drain", 32'(q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    add(32'h00510093,'h100,'hA,'h11,'hA,'h5,0,1,1,1,0,1,1);
    add(32'hFFB20193,'h104,'hFFFFFFFB,'h22,'hFFFFFFFB,
        'hFFFFFFFB,0,3,1,1,0,1,1);
    add(32'h007302B3,'h108,'h33,'h44,'h33,0,0,5,1,0,0,1,1);
    add(32'h407302B3,'h10C,'h55,'h66,'h55,0,1,5,1,0,0,1,1);
    add(32'h403150B3,'h110,'h80000000,'h3,'h80000000,0,
        7,1,1,0,0,1,1);
    add(32'h0020B033,'h114,'h1,'h2,'h1,0,9,0,0,0,0,1,1);
    add(32'hFFC12503,'h118,'h2000,'h7,'h2000,'hFFFFFFFC,
        0,10,1,1,0,1,1);
    add(32'hFE512FA3,'h11C,'h3000,'h5A5A,'h3000,'hFFFFFFFF,
        0,31,0,1,0,1,1);
    add(32'hFE208CE3,'h120,'h9,'h9,'h9,'hFFFFFFF8,
        0,25,0,0,0,0,1);
    add(32'h123453B7,'h124,'hDEAD,'hBEEF,0,'h12345000,
        0,7,1,1,0,1,1);
    add(32'hFFFFF417,'h128,'h77,'h88,'h128,'hFFFFF000,
        0,8,1,1,0,1,1);
    add(32'hFFDFF0EF,'h12C,'h99,'hAA,'h12C,'hFFFFFFFC,
        0,1,1,1,0,1,1);
    add(32'h00008067,'h130,'h400,'hBB,'h400,0,0,0,0,1,0,1,1);
    add(32'h00000000,'h134,'hCC,'hDD,'hCC,0,0,0,0,0,1,1,0);
    add(32'h0F01F113,'h138,'hFFFF,'h1,'hFFFF,'hF0,
        2,2,1,1,0,1,1);
    add(32'h4032D213,'h13C,'hF0000000,'h2,'hF0000000,'h403,
        7,4,1,1,0,1,1);

    cur = tbl[0];
    reset = 1; in_valid = 0; out_ready = 0; flush = 0;
    instr = 0; pc = 0; rs1_data = 0; rs2_data = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_reg_write", 32'(reg_write), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_srca", SrcA, 0);
    chk("rst_imm", Immediate, 0);
    chk("rst_illegal", 32'(illegal), 0);
    @(posedge clk);
    #1 reset = 0;

    // streaming table, consumer always ready
    foreach (tbl[i]) drive(tbl[i], 1, 1, 0);
    drive(tbl[0], 0, 1, 0);
    drain();

    // stall: B offered while A held for three cycles
    drive(tbl[0], 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(tbl[2], 1, 0, 0);
      @(negedge clk);
      #1;
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_out_valid", 32'(out_valid), 1);
      cmp(tbl[0]);
    end
    drive(tbl[2], 1, 1, 0);
    drive(tbl[2], 0, 1, 0);
    @(negedge clk);
    #1;
    chk("no_bubble", 32'(out_valid), 1);
    chk("no_bubble_pc", pc_q, tbl[2].pc);
    drain();

    // flush while full with a new instruction offered
    drive(tbl[3], 1, 0, 0);
    drive(tbl[4], 1, 1, 1);
    drive(tbl[4], 0, 0, 0);
    @(negedge clk);
    #1;
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_reg_write", 32'(reg_write), 0);
    drain();

    // asynchronous reset while full
    drive(tbl[0], 1, 0, 0);
    drive(tbl[0], 0, 0, 0);
    #2 reset = 1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_reg_write", 32'(reg_write), 0);
    chk("arst_srca", SrcA, 0);
    chk("arst_imm", Immediate, 0);
    @(posedge clk);
    #1 reset = 0;
    drive(tbl[1], 1, 1, 0);
    drive(tbl[1], 0, 1, 0);
    @(negedge clk);
    #1;
    chk("post_rst_capture", 32'(out_valid), 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
